gate_bist_controller: RTL

//  Stimulus/response end for the combinational gate-library models.
//  A 10-bit LFSR drives pseudo-random patterns onto a gate model's N1..N10

---
 rtl/gate_bist_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/gate_bist_controller.sv
// LFSR pattern source + MISR response compactor for combinational gate models.
// Optional macro RESP_PIPE_EN registers resp_i before the MISR and adds a FLUSH state.
module gate_bist_controller #(
    parameter int                N_IN       = 10,
    parameter int                N_OUT      = 10,
    parameter int                PATTERNS   = 1023,
    parameter logic [N_IN-1:0]   LFSR_SEED  = 'h001,
    parameter logic [N_IN-1:0]   LFSR_TAPS  = 'h240,
    parameter logic [N_OUT-1:0]  MISR_SEED  = 'h000,
    parameter logic [N_OUT-1:0]  MISR_TAPS  = 'h240,
    parameter logic [N_OUT-1:0]  GOLDEN_SIG = 'h000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic [N_IN-1:0]                 pat_o,
    input  logic [N_OUT-1:0]                resp_i,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [N_OUT-1:0]                signature,
    output logic [$clog2(PATTERNS+1)-1:0]   pat_count
);

    localparam int CW = $clog2(PATTERNS + 1);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [N_IN-1:0] SEED_EFF =
        (LFSR_SEED == '0) ? N_IN'(1) : LFSR_SEED;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              accept;
    logic              last;
    logic              enter_done;
    logic              misr_en;
    logic [N_OUT-1:0]  misr_in;
    logic [N_OUT-1:0]  sig_nx;
    logic [N_IN-1:0]   lfsr_nx;

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (state == RUN) && (pat_count == CW'(PATTERNS - 1));

    assign lfsr_nx = {pat_o[N_IN-2:0], ^(pat_o & LFSR_TAPS)};
    assign sig_nx  = {signature[N_OUT-2:0], ^(signature & MISR_TAPS)}
                     ^ misr_in;

    assign busy       = (state == RUN) || (state == FLUSH);
    assign done       = (state == DONE);
    assign enter_done = (state != DONE) && (state_nx == DONE);

`ifdef RESP_PIPE_EN
    logic [N_OUT-1:0] resp_q;
    logic             resp_v;

    // Response stage register; valid only for responses captured in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q <= '0;
            resp_v <= 1'b0;
        end else if (accept) begin
            resp_v <= 1'b0;
        end else if (state == RUN) begin
            resp_q <= resp_i;
            resp_v <= 1'b1;
        end else begin
            resp_v <= 1'b0;
        end
    end

    assign misr_in = resp_q;
    assign misr_en = resp_v;
`else
    assign misr_in = resp_i;
    assign misr_en = (state == RUN);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; start is only honoured when no run is in progress.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
`ifdef RESP_PIPE_EN
                if (last) state_nx = FLUSH;
`else
                if (last) state_nx = DONE;
`endif
            end
            FLUSH: begin
                state_nx = DONE;
            end
            DONE: begin
                if (start) state_nx = RUN;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Pattern generator, compactor, counter and verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_o     <= '0;
            signature <= MISR_SEED;
            pat_count <= '0;
            pass      <= 1'b0;
        end else if (accept) begin
            pat_o     <= SEED_EFF;
            signature <= MISR_SEED;
            pat_count <= '0;
            pass      <= 1'b0;
        end else begin
            if (state == RUN) begin
                pat_o     <= lfsr_nx;
                pat_count <= pat_count + CW'(1);
            end
            if (misr_en) begin
                signature <= sig_nx;
            end
            if (enter_done) begin
                pass <= (sig_nx == GOLDEN_SIG);
            end
        end
    end

endmodule
